// File: rtl/cbus_sram_responder.sv
// cbus responder backed by a word-addressed SRAM: single and INCR burst reads/writes
// with a fixed number of idle cycles between request acceptance and the first beat.
module cbus_sram_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        creq_valid_i,
    input  logic        creq_is_write_i,
    input  logic [2:0]  creq_size_i,
    input  logic [31:0] creq_addr_i,
    input  logic [7:0]  creq_len_i,
    input  logic [3:0]  creq_strobe_i,
    input  logic [31:0] creq_data_i,
    output logic        cresp_ready_o,
    output logic        cresp_last_o,
    output logic [31:0] cresp_data_o,
    output logic [1:0]  state_o
);
    // Handshake: the initiator holds valid and the request fields for the whole
    // transaction; one beat moves on every cycle with cresp_ready_o=1, and
    // cresp_last_o marks the final beat. Dropping valid early aborts the transaction.

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   base_q, base_d;
    logic [7:0]              len_q, len_d;
    logic                    wr_q, wr_d;
    logic [7:0]              beat_q, beat_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   word_idx;
    logic [31:0]             mem_q [DEPTH];

    // size, the byte offset and address bits above the SRAM have no effect
    logic unused_req_bits;
    assign unused_req_bits = ^{creq_size_i, creq_addr_i[1:0], creq_addr_i[31:DEPTH_LOG2+2]};

    // Beat offset added modulo the SRAM depth, so bursts wrap past the top word
    assign word_idx = base_q + DEPTH_LOG2'(beat_q);
    assign state_o  = state_q;

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        len_d         = len_q;
        wr_d          = wr_q;
        beat_d        = beat_q;
        cnt_d         = cnt_q;
        mem_we        = 1'b0;
        cresp_ready_o = 1'b0;
        cresp_last_o  = 1'b0;
        cresp_data_o  = '0;
        case (state_q)
            ST_IDLE: begin
                if (creq_valid_i) begin
                    base_d = creq_addr_i[DEPTH_LOG2+1:2];
                    len_d  = creq_len_i;
                    wr_d   = creq_is_write_i;
                    beat_d = '0;
                    if (LATENCY > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end else begin
                        state_d = ST_BURST;
                    end
                end
            end
            ST_WAIT: begin
                if (!creq_valid_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_BURST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_BURST: begin
                if (!creq_valid_i) begin
                    state_d = ST_IDLE;
                end else begin
                    cresp_ready_o = 1'b1;
                    mem_we        = wr_q;
                    cresp_data_o  = wr_q ? 32'd0 : mem_q[word_idx];
                    beat_d        = beat_q + 1'b1;
                    if (beat_q == len_q) begin
                        cresp_last_o = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A reset cycle aborts the beat: nothing is handshaken or written
        if (!resetn) begin
            cresp_ready_o = 1'b0;
            cresp_last_o  = 1'b0;
            cresp_data_o  = '0;
            mem_we        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            wr_q    <= 1'b0;
            beat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            wr_q    <= wr_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (creq_strobe_i[i]) begin
                    mem_q[word_idx][8*i +: 8] <= creq_data_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Bench for cbus_sram_responder: two instances (LATENCY 2 and 0, 16-word SRAM) driven by
// directed and random transactions, checked against a word-array model with timing rules.
module tb_cbus_sram_responder;
    localparam int LAT_A = 2;
    localparam int DL2   = 4;
    localparam int NW    = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic        is_write = 1'b0;
    logic [2:0]  size = '0;
    logic [31:0] addr = '0;
    logic [7:0]  len = '0;
    logic [3:0]  strobe = '0;
    logic [31:0] wdata = '0;
    logic        ready_a, last_a, ready_b, last_b;
    logic [31:0] data_a, data_b;
    logic [1:0]  state_a, state_b;

    logic [31:0] model_mem [2][NW];
    logic [31:0] wd [NW];
    logic [3:0]  st [NW];
    int          errors = 0;
    int          checks = 0;

    cbus_sram_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .resetn(resetn),
        .creq_valid_i(valid_a), .creq_is_write_i(is_write), .creq_size_i(size),
        .creq_addr_i(addr), .creq_len_i(len), .creq_strobe_i(strobe), .creq_data_i(wdata),
        .cresp_ready_o(ready_a), .cresp_last_o(last_a), .cresp_data_o(data_a),
        .state_o(state_a)
    );

    cbus_sram_responder #(.DEPTH_LOG2(DL2), .LATENCY(0)) u_dut_b (
        .clk(clk), .resetn(resetn),
        .creq_valid_i(valid_b), .creq_is_write_i(is_write), .creq_size_i(size),
        .creq_addr_i(addr), .creq_len_i(len), .creq_strobe_i(strobe), .creq_data_i(wdata),
        .cresp_ready_o(ready_b), .cresp_last_o(last_b), .cresp_data_o(data_b),
        .state_o(state_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            valid_a = 1'b0;
            valid_b = 1'b0;
            #1;
            check("idle_ready_a", 32'(ready_a), 32'd0);
            check("idle_ready_b", 32'(ready_b), 32'd0);
        end
    endtask

    // First beat lands 1+latency cycles after the request cycle; beats run back-to-back.
    task automatic do_txn(input int sel, input bit wr, input logic [31:0] a, input int n_len,
                          input int abort_beat, input bit rst_abort);
        int          lat;
        int          beat;
        int          idx;
        bit          abort_now;
        bit          aborted;
        logic        r, l;
        logic [31:0] d;
        lat = (sel == 0) ? LAT_A : 0;
        aborted = 1'b0;
        for (int c = 0; c <= 1 + lat + n_len; c++) begin
            if (!aborted) begin
                @(negedge clk);
                beat = c - 1 - lat;
                abort_now = (beat >= 0) && (beat == abort_beat);
                is_write = wr;
                addr = a;
                len = 8'(n_len);
                size = 3'($urandom_range(0, 7));
                wdata = (beat >= 0) ? wd[beat] : $urandom;
                strobe = (beat >= 0) ? st[beat] : 4'($urandom_range(0, 15));
                valid_a = (sel == 0) && !(abort_now && !rst_abort);
                valid_b = (sel == 1) && !(abort_now && !rst_abort);
                resetn = !(abort_now && rst_abort);
                #1;
                r = (sel == 0) ? ready_a : ready_b;
                l = (sel == 0) ? last_a : last_b;
                d = (sel == 0) ? data_a : data_b;
                if (abort_now) begin
                    check("abort_ready", 32'(r), 32'd0);
                    aborted = 1'b1;
                end else begin
                    check("ready", 32'(r), 32'(beat >= 0));
                    check("last", 32'(l), 32'(beat >= 0 && beat == n_len));
                    if (beat >= 0) begin
                        idx = (int'(a[5:2]) + beat) % NW;
                        if (wr) begin
                            check("wr_beat_data", d, 32'd0);
                            for (int b = 0; b < 4; b++)
                                if (st[beat][b]) model_mem[sel][idx][8*b +: 8] = wd[beat][8*b +: 8];
                        end else begin
                            check("rdata", d, model_mem[sel][idx]);
                        end
                    end else begin
                        check("wait_data", d, 32'd0);
                    end
                end
            end
        end
        if (aborted) begin
            @(negedge clk);
            resetn = 1'b1;
            valid_a = 1'b0;
            valid_b = 1'b0;
            #1;
            check("post_abort_ready", 32'(sel == 0 ? ready_a : ready_b), 32'd0);
            check("post_abort_state", 32'(sel == 0 ? state_a : state_b), 32'd0);
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            wd[i] = $urandom;
            st[i] = 4'hF;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_last", 32'(last_a), 32'd0);
        check("rst_data", data_a, 32'd0);
        check("rst_state", 32'(state_a), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Every word written once so later reads have defined contents
        fill_random(NW);
        do_txn(0, 1'b1, 32'h0, NW - 1, -1, 1'b0);
        fill_random(NW);
        do_txn(1, 1'b1, 32'h0, NW - 1, -1, 1'b0);
        idle(1);

        // Single write then read back
        wd[0] = 32'hDEADBEEF; st[0] = 4'hF;
        do_txn(0, 1'b1, 32'h10, 0, -1, 1'b0);
        do_txn(0, 1'b0, 32'h10, 0, -1, 1'b0);
        check("t1_model", model_mem[0][4], 32'hDEADBEEF);

        // Burst write 1..4 and burst read
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); st[i] = 4'hF; end
        do_txn(0, 1'b1, 32'h100, 3, -1, 1'b0);
        do_txn(0, 1'b0, 32'h100, 3, -1, 1'b0);

        // Partial strobe merge
        wd[0] = 32'h11223344; st[0] = 4'hF;
        do_txn(0, 1'b1, 32'h20, 0, -1, 1'b0);
        wd[0] = 32'hAABBCCDD; st[0] = 4'b0101;
        do_txn(0, 1'b1, 32'h20, 0, -1, 1'b0);
        do_txn(0, 1'b0, 32'h20, 0, -1, 1'b0);
        check("t3_model", model_mem[0][8], 32'h11BB33DD);

        // Zero-strobe write leaves the word alone
        wd[0] = 32'hFFFFFFFF; st[0] = 4'h0;
        do_txn(0, 1'b1, 32'h20, 0, -1, 1'b0);
        do_txn(0, 1'b0, 32'h20, 0, -1, 1'b0);

        // Wrap from index 14
        do_txn(0, 1'b0, 32'h38, 3, -1, 1'b0);
        fill_random(4);
        do_txn(1, 1'b1, 32'h38, 3, -1, 1'b0);
        do_txn(1, 1'b0, 32'h38, 3, -1, 1'b0);

        // Back-to-back: next request presented in the cycle right after last
        fill_random(2);
        do_txn(0, 1'b1, 32'h40, 1, -1, 1'b0);
        do_txn(0, 1'b0, 32'h40, 1, -1, 1'b0);
        fill_random(3);
        do_txn(0, 1'b1, 32'h48, 2, -1, 1'b0);
        do_txn(0, 1'b0, 32'h40, 4, -1, 1'b0);
        idle(2);

        // Reset during beat 2 of a len=7 write, then read back
        fill_random(8);
        do_txn(0, 1'b1, 32'h0, 7, 2, 1'b1);
        do_txn(0, 1'b0, 32'h0, 7, -1, 1'b0);

        // Valid dropped mid-burst
        fill_random(4);
        do_txn(0, 1'b1, 32'h30, 3, 1, 1'b0);
        do_txn(0, 1'b0, 32'h30, 3, -1, 1'b0);

        // Zero-latency instance
        fill_random(3);
        do_txn(1, 1'b1, 32'h14, 2, -1, 1'b0);
        do_txn(1, 1'b0, 32'h14, 2, -1, 1'b0);

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            int sel, ln, ab;
            sel = $urandom_range(0, 1);
            ln = $urandom_range(0, 7);
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, ln) : -1;
            for (int i = 0; i < NW; i++) begin
                wd[i] = $urandom;
                st[i] = 4'($urandom_range(0, 15));
            end
            do_txn(sel, 1'($urandom_range(0, 1)), $urandom, ln, ab, 1'b0);
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
